dispatch_pipe_arbiter: RTL and testbench

DISPATCH_PIPE_ARBITER -- requirements
Module: dispatch_pipe_arbiter

---
 rtl/dispatch_pipe_arbiter.sv | 121 ++++++++++++
 tb/tb_dispatch_pipe_arbiter.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/dispatch_pipe_arbiter.sv
// Two-slot dispatch arbiter: per-pipe RS credit tracking, collision priority, credit overflow flag.
// Optional performance counters are built only when DISP_ARB_PERF_EN is defined.
module dispatch_pipe_arbiter #(
  parameter int unsigned DISP_WIDTH = 2,
  parameter int unsigned NUM_FUS    = 4,
  parameter int unsigned RS_ENTRIES = 8,
  localparam int unsigned FU_IDX_W  = (NUM_FUS > 1) ? $clog2(NUM_FUS) : 1,
  localparam int unsigned CRED_W    = $clog2(RS_ENTRIES + 1)
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               stall,
  input  logic                               flush,
  input  logic [DISP_WIDTH-1:0]              req_valid,
  input  logic [DISP_WIDTH-1:0][FU_IDX_W-1:0] req_pipe,
  input  logic [NUM_FUS-1:0]                 rs_free,
  output logic [DISP_WIDTH-1:0]              grant,
  output logic [NUM_FUS-1:0]                 pipe_full,
  output logic                               prio_ptr,
  output logic                               credit_err,
  output logic [15:0]                        perf_collisions,
  output logic [15:0]                        perf_credit_stalls
);

  localparam logic [CRED_W-1:0] CRED_MAX = CRED_W'(RS_ENTRIES);

  logic [NUM_FUS-1:0][CRED_W-1:0] credit_q, credit_d;
  logic [DISP_WIDTH-1:0]          pipe_ok, has_credit, open;
  logic [NUM_FUS-1:0]             alloc;
  logic                           collision, prio_d, err_set;

  // Slot qualification and grant selection
  always_comb begin
    pipe_ok    = '0;
    has_credit = '0;
    open       = '0;
    grant      = '0;
    collision  = req_valid[0] & req_valid[1] & (req_pipe[0] == req_pipe[1]);
    for (int i = 0; i < int'(DISP_WIDTH); i++) begin
      pipe_ok[i]    = 32'(req_pipe[i]) < NUM_FUS;
      has_credit[i] = pipe_ok[i] && (credit_q[req_pipe[i]] != '0);
      open[i]       = req_valid[i] & ~stall & ~flush & ~rst;
      grant[i]      = open[i] & has_credit[i] & (~collision | (prio_ptr == 1'(i)));
    end
  end

  // Credit next-state: allocate on grant, return on rs_free, saturate at full
  always_comb begin
    alloc    = '0;
    credit_d = credit_q;
    err_set  = 1'b0;
    for (int i = 0; i < int'(DISP_WIDTH); i++) begin
      for (int p = 0; p < int'(NUM_FUS); p++) begin
        if (grant[i] && (req_pipe[i] == FU_IDX_W'(p))) alloc[p] = 1'b1;
      end
    end
    for (int p = 0; p < int'(NUM_FUS); p++) begin
      if (flush) begin
        credit_d[p] = CRED_MAX;
      end else if (rs_free[p] && !alloc[p]) begin
        if (credit_q[p] == CRED_MAX) err_set = 1'b1;
        else credit_d[p] = credit_q[p] + CRED_W'(1);
      end else if (alloc[p] && !rs_free[p]) begin
        credit_d[p] = credit_q[p] - CRED_W'(1);
      end
    end
  end

  // Priority flips only after a collision that the priority slot actually won
  always_comb begin
    prio_d = prio_ptr;
    if (flush) prio_d = 1'b0;
    else if (collision && grant[prio_ptr]) prio_d = ~prio_ptr;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      credit_q   <= {NUM_FUS{CRED_MAX}};
      prio_ptr   <= 1'b0;
      credit_err <= 1'b0;
    end else begin
      credit_q <= credit_d;
      prio_ptr <= prio_d;
      if (err_set) credit_err <= 1'b1;
    end
  end

  always_comb begin
    for (int p = 0; p < int'(NUM_FUS); p++) pipe_full[p] = (credit_q[p] == '0);
  end

`ifdef DISP_ARB_PERF_EN
  logic [15:0] coll_q, cstall_q;
  logic        starved;

  always_comb begin
    starved = 1'b0;
    for (int i = 0; i < int'(DISP_WIDTH); i++) begin
      if (open[i] && pipe_ok[i] && !has_credit[i]) starved = 1'b1;
    end
  end

  // Saturating event counters
  always_ff @(posedge clk) begin
    if (rst) begin
      coll_q   <= '0;
      cstall_q <= '0;
    end else begin
      if (collision && (coll_q != 16'hFFFF)) coll_q <= coll_q + 16'd1;
      if (starved && (cstall_q != 16'hFFFF)) cstall_q <= cstall_q + 16'd1;
    end
  end

  assign perf_collisions    = coll_q;
  assign perf_credit_stalls = cstall_q;
`else
  assign perf_collisions    = '0;
  assign perf_credit_stalls = '0;
`endif

endmodule

// File: tb/tb_dispatch_pipe_arbiter.sv
// Directed bench for dispatch_pipe_arbiter (NUM_FUS=4, RS_ENTRIES=4) with a cycle-level reference model.
module tb_dispatch_pipe_arbiter;

  localparam int NF = 4;
  localparam int RE = 4;

  logic            clk = 1'b0;
  logic            rst, stall, flush;
  logic [1:0]      req_valid;
  logic [1:0][1:0] req_pipe;
  logic [3:0]      rs_free;
  logic [1:0]      grant;
  logic [3:0]      pipe_full;
  logic            prio_ptr, credit_err;
  logic [15:0]     perf_collisions, perf_credit_stalls;

  int n_cmp = 0;
  int n_bad = 0;

  int m_cred [NF];
  bit m_prio, m_err;
  int m_coll, m_cstall;

  dispatch_pipe_arbiter #(.DISP_WIDTH(2), .NUM_FUS(NF), .RS_ENTRIES(RE)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .req_valid(req_valid), .req_pipe(req_pipe), .rs_free(rs_free),
    .grant(grant), .pipe_full(pipe_full), .prio_ptr(prio_ptr), .credit_err(credit_err),
    .perf_collisions(perf_collisions), .perf_credit_stalls(perf_credit_stalls)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic bit is_collision();
    return (req_valid == 2'b11) && (req_pipe[0] == req_pipe[1]);
  endfunction

  function automatic logic [1:0] model_grant();
    logic [1:0] g = 2'b00;
    if (!rst && !stall && !flush) begin
      for (int i = 0; i < 2; i++)
        if (req_valid[i] && m_cred[req_pipe[i]] > 0) g[i] = 1'b1;
      if (is_collision()) g[m_prio ? 0 : 1] = 1'b0;
    end
    return g;
  endfunction

  function automatic void model_reset();
    for (int p = 0; p < NF; p++) m_cred[p] = RE;
    m_prio = 0; m_err = 0; m_coll = 0; m_cstall = 0;
  endfunction

  initial model_reset();

  // Per-cycle comparison against the model, then advance the model one edge
  always @(negedge clk) begin
    logic [1:0] eg;
    logic [3:0] ef;
    bit         starved;
    eg = model_grant();
    for (int p = 0; p < NF; p++) ef[p] = (m_cred[p] == 0);
    check("grant", 32'(grant), 32'(eg));
    check("pipe_full", 32'(pipe_full), 32'(ef));
    check("prio_ptr", 32'(prio_ptr), 32'(m_prio));
    check("credit_err", 32'(credit_err), 32'(m_err));
`ifdef DISP_ARB_PERF_EN
    check("perf_collisions", 32'(perf_collisions), 32'(m_coll));
    check("perf_credit_stalls", 32'(perf_credit_stalls), 32'(m_cstall));
`else
    check("perf_collisions", 32'(perf_collisions), 32'd0);
    check("perf_credit_stalls", 32'(perf_credit_stalls), 32'd0);
`endif
    if (rst) begin
      model_reset();
    end else begin
      starved = 0;
      for (int i = 0; i < 2; i++)
        if (req_valid[i] && !stall && !flush && m_cred[req_pipe[i]] == 0) starved = 1;
      if (is_collision() && m_coll < 65535) m_coll++;
      if (starved && m_cstall < 65535) m_cstall++;
      if (flush) begin
        for (int p = 0; p < NF; p++) m_cred[p] = RE;
        m_prio = 0;
      end else begin
        for (int p = 0; p < NF; p++) begin
          bit taken, freed;
          taken = (eg[0] && req_pipe[0] == 2'(p)) || (eg[1] && req_pipe[1] == 2'(p));
          freed = rs_free[p];
          if (freed && !taken && m_cred[p] == RE) m_err = 1;
          else m_cred[p] = m_cred[p] - int'(taken) + int'(freed);
        end
        if (is_collision() && eg[m_prio]) m_prio = ~m_prio;
      end
    end
  end

  task automatic drive(input logic [1:0] v, input int p0, input int p1, input logic [3:0] fr,
                       input logic st = 1'b0, input logic fl = 1'b0, input logic r = 1'b0);
    @(posedge clk);
    #1;
    req_valid = v; req_pipe[0] = 2'(p0); req_pipe[1] = 2'(p1);
    rs_free = fr; stall = st; flush = fl; rst = r;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0; req_valid = '0; req_pipe = '0; rs_free = '0;
    drive(2'b11, 1, 1, 4'b0000, 1'b0, 1'b0, 1'b1);
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_pipe_full", 32'(pipe_full), 32'd0);
    check("rst_prio", 32'(prio_ptr), 32'd0);
    check("rst_err", 32'(credit_err), 32'd0);
    check("rst_perf", 32'(perf_collisions), 32'd0);

    // Independent pipes, both granted
    drive(2'b11, 2, 3, 4'b0000);
    check("indep_grant", 32'(grant), 32'b11);

    // Four-cycle collision on pipe 1 alternates priority
    for (int k = 0; k < 4; k++) begin
      drive(2'b11, 1, 1, 4'b0000);
      check("coll_grant", 32'(grant), (k % 2 == 0) ? 32'b01 : 32'b10);
    end
    drive(2'b00, 0, 0, 4'b0000);
    check("coll_full", 32'(pipe_full), 32'b0010);
`ifdef DISP_ARB_PERF_EN
    check("coll_perf", 32'(perf_collisions), 32'd4);
`else
    check("coll_perf", 32'(perf_collisions), 32'd0);
`endif

    // Drain pipe 0, then a freed credit is usable only one cycle later
    for (int k = 0; k < 4; k++) drive(2'b01, 0, 0, 4'b0000);
    drive(2'b01, 0, 0, 4'b0001);
    check("nobypass_n", 32'(grant), 32'b00);
    drive(2'b01, 0, 0, 4'b0000);
    check("nobypass_n1", 32'(grant), 32'b01);
    drive(2'b00, 0, 0, 4'b0000);
    check("drained_full", 32'(pipe_full), 32'b0011);

    // Grant and free on the same pipe keep credit at 1
    drive(2'b00, 0, 0, 4'b0001);
    drive(2'b01, 0, 0, 4'b0001);
    check("same_cyc_grant", 32'(grant), 32'b01);
    drive(2'b00, 0, 0, 4'b0000);
    check("same_cyc_full", 32'(pipe_full), 32'b0010);
    check("same_cyc_err", 32'(credit_err), 32'd0);
    drive(2'b01, 0, 0, 4'b0000);
    check("last_credit", 32'(grant), 32'b01);
    drive(2'b00, 0, 0, 4'b0000);
    check("last_full", 32'(pipe_full), 32'b0011);

    // Overflow on pipe 2 saturates at RS_ENTRIES and sets the sticky error
    drive(2'b00, 0, 0, 4'b0100);
    drive(2'b00, 0, 0, 4'b0100);
    drive(2'b00, 0, 0, 4'b0000);
    check("overflow_err", 32'(credit_err), 32'd1);
    for (int k = 0; k < 4; k++) drive(2'b01, 2, 0, 4'b0000);
    drive(2'b01, 2, 0, 4'b0000);
    check("sat_at_max", 32'(grant), 32'b00);

    // Flush with zero credits and rs_free set restores everything
    drive(2'b11, 3, 3, 4'b0000);
    check("prio_set_grant", 32'(grant), 32'b01);
    drive(2'b00, 0, 0, 4'b0000);
    check("prio_one", 32'(prio_ptr), 32'd1);
    drive(2'b11, 0, 1, 4'b1111, 1'b0, 1'b1);
    check("flush_grant", 32'(grant), 32'b00);
    drive(2'b11, 0, 1, 4'b0000);
    check("post_flush_prio", 32'(prio_ptr), 32'd0);
    check("post_flush_full", 32'(pipe_full), 32'd0);
    check("post_flush_grant", 32'(grant), 32'b11);
    check("err_sticky", 32'(credit_err), 32'd1);
    drive(2'b11, 0, 1, 4'b0000, 1'b1);
    check("stall_grant", 32'(grant), 32'b00);

    // Mixed traffic, checked by the model every cycle
    for (int k = 0; k < 300; k++) begin
      drive(2'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
            4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15)),
            ($urandom_range(0, 7) == 0), ($urandom_range(0, 15) == 0), ($urandom_range(0, 63) == 0));
    end

    drive(2'b00, 0, 0, 4'b0000, 1'b0, 1'b0, 1'b1);
    drive(2'b00, 0, 0, 4'b0000);
    check("final_err_clear", 32'(credit_err), 32'd0);
    check("final_perf_clear", 32'(perf_credit_stalls), 32'd0);

    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
